imem_loader: RTL

Boot-time instruction-memory writer for the single-cycle RISC-V core. It accepts a framed byte stream, for example from a UART receiver, and assembles little-endian 32-bit words. It writes those words sequentially into the IMEM write port. It holds the core in reset until a complete, checksum-valid image is loaded; the IMEM read side is the instruction fetch path.

---
 rtl/loader_pkg.sv | 21 ++
 rtl/word_assembler.sv | 42 ++++
 rtl/imem_loader.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared constants and types for the boot-time IMEM loader: sync byte,
// frame-parser states and error codes reported on the error port.
package loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN0 = 3'd1,
    LEN1 = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;

endpackage

// File: rtl/word_assembler.sv
// Packs four strobed bytes, least-significant first, into a 32-bit word.
// word_valid is combinational on the 4th byte so the caller can register it.
module word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  idx_q, idx_d;
  logic [23:0] shift_q, shift_d;

  always_comb begin
    idx_d   = idx_q;
    shift_d = shift_q;
    if (clear) begin
      idx_d   = 2'd0;
      shift_d = 24'd0;
    end else if (byte_valid) begin
      idx_d   = idx_q + 2'd1;
      // Bytes enter at the top and slide down, so byte 0 ends up in [7:0].
      shift_d = {byte_in, shift_q[23:8]};
    end
  end

  assign word       = {byte_in, shift_q};
  assign word_valid = byte_valid && !clear && (idx_q == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= 2'd0;
      shift_q <= 24'd0;
    end else begin
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Parses SYNC/length/data/checksum frames and writes words into IMEM,
// holding the core in reset until a checksum-valid image has been loaded.
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_hold,
  output logic                  done,
  output logic [1:0]            error,
  output logic [15:0]           words_loaded,
  output logic [2:0]            dbg_state
);

  // Handshake: a byte transfers on a cycle where in_valid & in_ready are
  // both high; in_ready is high in every state once out of reset.

  localparam logic [16:0] DEPTH = 17'd1 << ADDR_WIDTH;

  state_e                state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic [7:0]            len_lo_q, len_lo_d;
  logic [15:0]           n_q, n_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           words_q, words_d;
  logic [7:0]            csum_q, csum_d;
  logic                  imem_we_q, imem_we_d;
  logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]           imem_wdata_q, imem_wdata_d;
  logic                  core_hold_q, core_hold_d;
  logic                  done_q, done_d;
  logic [1:0]            error_q, error_d;

  logic        accept;
  logic [15:0] len_n;
  logic [31:0] asm_word;
  logic        asm_word_valid;

  assign accept = in_valid && in_ready_q;
  assign len_n  = {in_data, len_lo_q};

  word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (accept && (state_q == LEN1)),
    .byte_in    (in_data),
    .byte_valid (accept && (state_q == DATA)),
    .word       (asm_word),
    .word_valid (asm_word_valid)
  );

  always_comb begin
    state_d      = state_q;
    in_ready_d   = 1'b1;
    len_lo_d     = len_lo_q;
    n_d          = n_q;
    addr_d       = addr_q;
    words_d      = words_q;
    csum_d       = csum_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    core_hold_d  = core_hold_q;
    done_d       = done_q;
    error_d      = error_q;

    case (state_q)
      IDLE: if (accept && in_data == SYNC_BYTE) state_d = LEN0;
      LEN0: if (accept) begin
        len_lo_d = in_data;
        state_d  = LEN1;
      end
      LEN1: if (accept) begin
        n_d = len_n;
        if ({1'b0, len_n} > DEPTH) begin
          state_d = ERR;
          error_d = ERR_LEN;
        end else begin
          // Zero-length frames still need a clean accumulator for CSUM.
          addr_d  = '0;
          words_d = 16'd0;
          csum_d  = 8'd0;
          state_d = (len_n == 16'd0) ? CSUM : DATA;
        end
      end
      DATA: if (accept) begin
        csum_d = csum_q ^ in_data;
        if (asm_word_valid) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = addr_q;
          imem_wdata_d = asm_word;
          addr_d       = addr_q + 1'b1;
          words_d      = words_q + 16'd1;
          if (words_q + 16'd1 == n_q) state_d = CSUM;
        end
      end
      CSUM: if (accept) begin
        if (in_data == csum_q) begin
          state_d     = DONE;
          done_d      = 1'b1;
          core_hold_d = 1'b0;
        end else begin
          state_d = ERR;
          error_d = ERR_CSUM;
        end
      end
      DONE, ERR: if (accept && in_data == SYNC_BYTE) begin
        state_d     = LEN0;
        core_hold_d = 1'b1;
        done_d      = 1'b0;
        error_d     = ERR_NONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b0;
      len_lo_q     <= 8'd0;
      n_q          <= 16'd0;
      addr_q       <= '0;
      words_q      <= 16'd0;
      csum_q       <= 8'd0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'd0;
      core_hold_q  <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      len_lo_q     <= len_lo_d;
      n_q          <= n_d;
      addr_q       <= addr_d;
      words_q      <= words_d;
      csum_q       <= csum_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_hold_q  <= core_hold_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign imem_we      = imem_we_q;
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign core_hold    = core_hold_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_q;
  assign dbg_state    = state_q;

endmodule
